// File: rtl/deser_pkg.sv
// deser_pkg: shared lane geometry for the 1:8 deserializer and its output register.
package deser_pkg;
    localparam int LANES      = 8;
    localparam int LANE_IDX_W = 3;
    localparam int CNT_W      = 4;

    function automatic int lane_off(input int i, input int dw);
        return i * dw;
    endfunction
endpackage

// File: rtl/bundle_out_reg.sv
// bundle_out_reg: double-buffer output slot; load wins over consume so back-to-back bundles never bubble.
// out_cnt port exists only with DESER_1TO8_FLUSH_EN.
module bundle_out_reg
    import deser_pkg::*;
#(
    parameter int DW_DATA = 128
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load,
    input  logic [LANES*DW_DATA-1:0]           load_data,
`ifdef DESER_1TO8_FLUSH_EN
    input  logic [CNT_W-1:0]                   load_cnt,
    output logic [CNT_W-1:0]                   out_cnt,
`endif
    input  logic                               out_ready,
    output logic                               out_valid,
    output logic signed [LANES*DW_DATA-1:0]    out_data
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef DESER_1TO8_FLUSH_EN
            out_cnt   <= '0;
`endif
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
`ifdef DESER_1TO8_FLUSH_EN
            out_cnt   <= load_cnt;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/deser_1to8.sv
// deser_1to8: packs eight accepted words into one bundle, lane i = i-th word.
// DESER_1TO8_FLUSH_EN adds flush/out_cnt for emitting partial bundles.
module deser_1to8
    import deser_pkg::*;
#(
    parameter int DW_DATA = 128
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [DW_DATA-1:0]          in_data,
`ifdef DESER_1TO8_FLUSH_EN
    input  logic                               flush,
    output logic [CNT_W-1:0]                   out_cnt,
`endif
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [LANES*DW_DATA-1:0]    out_data
);
    logic [LANE_IDX_W-1:0]    cnt;
    logic [LANES*DW_DATA-1:0] fill, fill_nxt;
    logic                     slot_free, acc, last, load;

    assign slot_free = !out_valid || out_ready;
    assign last      = cnt == LANE_IDX_W'(LANES - 1);
    // only the closing word needs a free slot; earlier words fill behind a held bundle
    assign in_ready  = !last || slot_free;
    assign acc       = in_valid && in_ready;

    always_comb begin
        fill_nxt = fill;
        if (acc) fill_nxt[lane_off(int'(cnt), DW_DATA) +: DW_DATA] = in_data;
    end

`ifdef DESER_1TO8_FLUSH_EN
    logic [CNT_W-1:0] load_cnt;
    assign load     = (acc && last) || (flush && slot_free && (cnt != '0 || acc));
    assign load_cnt = {1'b0, cnt} + CNT_W'(acc);
`else
    assign load     = acc && last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            fill <= '0;
        end else if (load) begin
            cnt  <= '0;
            fill <= '0;
        end else if (acc) begin
            cnt  <= cnt + 1'b1;
            fill <= fill_nxt;
        end
    end

    bundle_out_reg #(.DW_DATA(DW_DATA)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (fill_nxt),
`ifdef DESER_1TO8_FLUSH_EN
        .load_cnt  (load_cnt),
        .out_cnt   (out_cnt),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );
endmodule

// File: doc/deser_1to8.md
# deser_1to8

Word-to-bundle deserializer: collects eight consecutive DW_DATA-wide words from a valid/ready stream and packs them into one 8*DW_DATA bundle. It sits directly upstream of the team's registered 8:1 lane mux and fills that mux's packed input bus. Lane i of the bundle is the i-th accepted word, matching the mux's sel-to-lane mapping (sel=i selects bits i*DW_DATA +: DW_DATA). Output is double-buffered, so a full bundle can drain while the next one fills.

## Interface
- DW_DATA, default 128 (32*4): width of one word/lane, signed.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  block accepts a word this cycle.
- in_data  in  DW_DATA  signed word.
- out_valid  out  1  bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_data  out  8*DW_DATA  signed packed bundle; lane i at bits i*DW_DATA +: DW_DATA.
- flush  in  1  present only with DESER_1TO8_FLUSH_EN; emit the partial bundle.
- out_cnt  out  4  present only with DESER_1TO8_FLUSH_EN; number of valid lanes, 1..8.

## Operation
- Fill register: 8 lanes plus a 3-bit lane counter cnt. Output register: out_data, out_valid, out_cnt.
- Transfers:
  - A word is accepted when in_valid && in_ready. It is written to lane cnt, and cnt increments.
  - A bundle is consumed when out_valid && out_ready.
- The output slot is free when !out_valid || out_ready.
- in_ready = (cnt != 7) || slot_free. This is a combinational path from out_ready; it is required.
- Accepting the word at cnt==7 loads the output register in the same edge with the 7 stored lanes plus in_data. cnt wraps to 0, and the fill lanes clear to zero.
- A bundle consumption and a new load in the same cycle: the new bundle replaces the old one, and out_valid stays 1.
- Consumption with no new load: out_valid goes to 0. out_data holds its last value.
- out_data and out_valid change only on these transfers; they are stable while out_valid && !out_ready.
- There is no explicit FSM; the state is cnt plus out_valid.
- Reset, including mid-fill or mid-handshake:
  - cnt=0, all fill lanes=0.
  - out_valid=0, out_data=0, out_cnt=0.
  - Partial data is discarded.
- No arithmetic. Data is passed through bit-exact, with no sign extension.

## Timing
- Latency: out_valid rises on the clock edge that accepts the 8th word; it is visible the following cycle.
- Throughput: 1 word/cycle sustained when out_ready is held high. One bundle every 8 cycles with no bubbles.
- Backpressure: if out_valid=1 and out_ready=0, words 0..6 of the next bundle are still accepted. Word 7 stalls (in_ready=0) until the slot frees.
- in_ready does not depend on in_valid.

## Configuration
- DESER_1TO8_FLUSH_EN defined:
  - flush and out_cnt ports exist. Full bundles report out_cnt=8.
  - flush is acted on only in cycles where the slot is free. Otherwise the source holds flush high.
  - If flush is acted on with cnt>0, or with an accepted word in the same cycle: the accepted word is written first. The bundle is then emitted with out_cnt = lanes filled, unfilled lanes zero, and cnt reset to 0.
  - flush with cnt==0 and no word accepted is ignored.
- DESER_1TO8_FLUSH_EN undefined: no flush or out_cnt ports, and only complete 8-lane bundles are emitted.

## Structure
- Shared package deser_pkg holds:
  - LANES=8
  - LANE_IDX_W=3
  - CNT_W=4
  - the lane-offset constant/function i*DW_DATA
- One sub-module is natural: bundle_out_reg, the output holding register with valid/ready load logic and async reset.

## Test plan
- Reset, then words 1..8 with out_ready=1 -> one bundle; lane0=1 … lane7=8; out_valid high for exactly 1 cycle.
- 24 back-to-back words with out_ready=1 -> 3 bundles at 8-cycle spacing; in_ready never drops.
- Backpressure: out_ready=0 after the first bundle, then 8 more words -> in_ready=0 on word 7. Release out_ready -> the first bundle is consumed, word 7 is accepted, and the second bundle is valid next cycle.
- Assert rst after 5 words, then send words 0x10..0x17 -> the bundle contains only 0x10..0x17 in lanes 0..7, and out_data=0 before it.
- Flush enabled: 3 words 0xA,0xB,0xC, then flush -> out_cnt=3, lanes0..2=A,B,C, lanes3..7=0. A flush with cnt=0 produces no out_valid.
- Flush enabled: flush with in_valid in the same cycle at cnt=4 -> out_cnt=5, the new word is in lane 4.
